alu64_sequencer: RTL and testbench

ALU64_SEQUENCER -- requirements
Module: alu64_sequencer

---
 rtl/alu64_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu64_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu64_sequencer.sv
// Walks a fixed eight-op table through an external ALU and streams each result
// (plus flags) as a valid/ready beat, then pulses done.
module alu64_sequencer #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             abort,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_Y,
  input  logic             alu_ZF,
  input  logic             alu_SF,
  input  logic             alu_CF,
  input  logic             alu_OF,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_op,
  output logic [WIDTH-1:0] res_y,
  output logic [3:0]       res_flags,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | op on the ALU bus, waiting ALU_LAT+1 cycles for the result
  // OUT   | captured result offered to the consumer
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_OUT, S_DONE} state_e;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       wait_q, wait_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       op_q, op_d;
  logic             last_q, last_d;

  function automatic logic [3:0] op_at(input logic [2:0] i);
    case (i)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0011;
      3'd4:    return 4'b0100;
      3'd5:    return 4'b0101;
      3'd6:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
      op_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      op_q    <= op_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    flags_d = flags_q;
    op_d    = op_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = '0;
          wait_d  = LAT_LOAD;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wait_q == 4'd0) begin
          y_d     = alu_Y;
          flags_d = {alu_ZF, alu_SF, alu_CF, alu_OF};
          op_d    = op_at(idx_q);
          last_d  = (idx_q == 3'd7);
          state_d = S_OUT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (idx_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            wait_d  = LAT_LOAD;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins the next state even when a beat transfers in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  assign alu_A     = a_q;
  assign alu_B     = b_q;
  assign alu_op    = ((state_q == S_ISSUE) || (state_q == S_OUT)) ? op_at(idx_q) : 4'b0000;
  assign res_valid = (state_q == S_OUT);
  assign res_op    = op_q;
  assign res_y     = y_q;
  assign res_flags = flags_q;
  assign res_last  = last_q && (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_alu64_sequencer.sv
// Directed bench: two sequencers (ALU_LAT 1 and 3) each fronting a behavioural ALU.
module tb_alu64_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start1, start3, abort, res_ready;
  logic [63:0] a_in, b_in;

  logic [63:0] A1, B1, Y1, ry1;
  logic [3:0]  op1, rop1, rfl1;
  logic        zf1, sf1, cf1, of1, vld1, last1, busy1, done1;

  logic [63:0] A3, B3, Y3, ry3;
  logic [3:0]  op3, rop3, rfl3;
  logic        zf3, sf3, cf3, of3, vld3, last3, busy3, done3;

  alu64_sequencer #(.WIDTH(64), .ALU_LAT(1)) d1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in), .abort(abort),
    .alu_A(A1), .alu_B(B1), .alu_op(op1), .alu_Y(Y1),
    .alu_ZF(zf1), .alu_SF(sf1), .alu_CF(cf1), .alu_OF(of1),
    .res_valid(vld1), .res_ready(res_ready), .res_op(rop1), .res_y(ry1),
    .res_flags(rfl1), .res_last(last1), .busy(busy1), .done(done1)
  );

  alu64_sequencer #(.WIDTH(64), .ALU_LAT(3)) d3 (
    .clk(clk), .rst(rst), .start(start3), .a_in(a_in), .b_in(b_in), .abort(abort),
    .alu_A(A3), .alu_B(B3), .alu_op(op3), .alu_Y(Y3),
    .alu_ZF(zf3), .alu_SF(sf3), .alu_CF(cf3), .alu_OF(of3),
    .res_valid(vld3), .res_ready(res_ready), .res_op(rop3), .res_y(ry3),
    .res_flags(rfl3), .res_last(last3), .busy(busy3), .done(done3)
  );

  // Behavioural ALU returning {ZF,SF,CF,OF,Y}
  function automatic logic [67:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] y;
    logic        cf, ovf;
    s = '0; y = '0; cf = 1'b0; ovf = 1'b0;
    case (op)
      4'b0000: begin s = {1'b0, a} + {1'b0, b}; y = s[63:0]; cf = s[64]; ovf = (a[63] == b[63]) && (y[63] != a[63]); end
      4'b0001: begin s = {1'b0, a} - {1'b0, b}; y = s[63:0]; cf = s[64]; ovf = (a[63] != b[63]) && (y[63] != a[63]); end
      4'b0010: y = a * b;
      4'b0011: y = a & b;
      4'b0100: y = a | b;
      4'b0101: y = a ^ b;
      4'b0111: y = ~a;
      4'b1111: y = a;
      default: y = '0;
    endcase
    return {(y == 64'd0), y[63], cf, ovf, y};
  endfunction

  logic [67:0] p1;
  logic [67:0] p3 [3];
  always @(posedge clk) p1 <= alu_f(op1, A1, B1);
  always @(posedge clk) begin
    p3[0] <= alu_f(op3, A3, B3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign Y1 = p1[63:0];
  assign {zf1, sf1, cf1, of1} = p1[67:64];
  assign Y3 = p3[2][63:0];
  assign {zf3, sf3, cf3, of3} = p3[2][67:64];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit use3 = 1'b0;
  wire        m_vld  = use3 ? vld3  : vld1;
  wire [63:0] m_y    = use3 ? ry3   : ry1;
  wire [3:0]  m_op   = use3 ? rop3  : rop1;
  wire [3:0]  m_fl   = use3 ? rfl3  : rfl1;
  wire        m_last = use3 ? last3 : last1;
  wire        m_done = use3 ? done3 : done1;
  wire        m_busy = use3 ? busy3 : busy1;

  logic [63:0] ey  [8] = '{64'd15, 64'd5, 64'd50, 64'd0, 64'd15, 64'd15, 64'hFFFF_FFFF_FFFF_FFF5, 64'd10};
  logic [3:0]  eop [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b1111};

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [63:0] by   [8];
  logic [3:0]  bop  [8];
  logic [3:0]  bfl  [8];
  logic        blast[8];
  int          bcyc [8];
  int nb, nd, done_cyc, stall_bad, stall_n, start_cyc;

  task automatic start_run(input logic [63:0] a, input logic [63:0] b);
    a_in = a; b_in = b;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
  endtask

  // Runs until done or budget; optional stall of one beat and start poking.
  task automatic collect(input int stall_beat, input int stall_len, input bit poke);
    logic [63:0] sy;
    logic [3:0]  sop;
    nb = 0; nd = 0; done_cyc = -1; stall_bad = 0; stall_n = 0; sy = '0; sop = '0;
    for (int i = 0; i < 8; i++) begin
      by[i] = 'x; bop[i] = 'x; bfl[i] = 'x; blast[i] = 1'bx; bcyc[i] = -100;
    end
    for (int t = 0; t < 400 && nd == 0; t++) begin
      if (m_done) begin nd++; done_cyc = cyc; end
      if (nb == stall_beat && stall_n < stall_len && (stall_n > 0 || m_vld)) begin
        res_ready = 1'b0;
        if (stall_n == 0) begin sy = m_y; sop = m_op; end
        else if (!m_vld || m_y !== sy || m_op !== sop) stall_bad++;
        stall_n++;
      end else begin
        res_ready = 1'b1;
      end
      if (poke) begin
        a_in = 64'd99; b_in = 64'd99;
        start1 = !m_done && (t % 3 == 0);
      end
      if (m_vld && res_ready) begin
        if (nb < 8) begin
          by[nb] = m_y; bop[nb] = m_op; bfl[nb] = m_fl; blast[nb] = m_last; bcyc[nb] = cyc;
        end
        nb++;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic check_std(input string p, input int gap, input int first);
    int gbad, lbad;
    gbad = 0; lbad = 0;
    chk({p, "_nbeats"}, 64'(nb), 64'd8);
    chk({p, "_ndone"}, 64'(nd), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_y%0d", p, i), by[i], ey[i]);
      chk($sformatf("%s_op%0d", p, i), 64'(bop[i]), 64'(eop[i]));
      if (blast[i] !== (i == 7)) lbad++;
      if (i > 0 && gap > 0 && (bcyc[i] - bcyc[i-1]) != gap) gbad++;
    end
    chk({p, "_last"}, 64'(lbad), 64'd0);
    chk({p, "_and_zf"}, 64'(bfl[3][3]), 64'd1);
    chk({p, "_done_time"}, 64'(done_cyc), 64'(bcyc[7] + 1));
    if (gap > 0) chk({p, "_gap"}, 64'(gbad), 64'd0);
    if (first > 0) chk({p, "_first"}, 64'(bcyc[0] - start_cyc), 64'(first));
    chk({p, "_idle_busy"}, 64'(m_busy), 64'd0);
    chk({p, "_idle_done"}, 64'(m_done), 64'd0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_valid"}, 64'(vld1), 64'd0);
    chk({p, "_busy"}, 64'(busy1), 64'd0);
    chk({p, "_done"}, 64'(done1), 64'd0);
    chk({p, "_last"}, 64'(last1), 64'd0);
    chk({p, "_y"}, ry1, 64'd0);
    chk({p, "_flags"}, 64'(rfl1), 64'd0);
    chk({p, "_rop"}, 64'(rop1), 64'd0);
    chk({p, "_aluop"}, 64'(op1), 64'd0);
    chk({p, "_A"}, A1, 64'd0);
    chk({p, "_B"}, B1, 64'd0);
  endtask

  initial begin
    int found, bad;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; abort = 1'b0; res_ready = 1'b0;
    a_in = 64'd7; b_in = 64'd7;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    chk("rst0_busy3", 64'(busy3), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal run
    start_run(64'd10, 64'd5);
    collect(-1, 0, 1'b0);
    check_std("nom", 3, 3);

    // Consumer stall on beat 3
    start_run(64'd10, 64'd5);
    collect(2, 20, 1'b0);
    chk("stall_len", 64'(stall_n), 64'd20);
    chk("stall_stable", 64'(stall_bad), 64'd0);
    chk("stall_gap", 64'(bcyc[2] - bcyc[1]), 64'd23);
    check_std("stall", 0, 3);

    // Abort during ISSUE of op 4
    start_run(64'd10, 64'd5);
    res_ready = 1'b1;
    found = 0;
    for (int t = 0; t < 60 && found == 0; t++) begin
      if (busy1 && !vld1 && op1 == 4'b0100) begin
        found = 1;
        abort = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_reach", 64'(found), 64'd1);
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_valid", 64'(vld1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      if (vld1 || done1 || busy1) bad++;
      @(negedge clk);
    end
    chk("abort_quiet", 64'(bad), 64'd0);
    start_run(64'd3, 64'd3);
    collect(-1, 0, 1'b0);
    chk("abort_new_nbeats", 64'(nb), 64'd8);
    chk("abort_new_sub_y", by[1], 64'd0);
    chk("abort_new_sub_zf", 64'(bfl[1][3]), 64'd1);

    // Abort and start together in IDLE: start is accepted
    a_in = 64'd10; b_in = 64'd5;
    start1 = 1'b1; abort = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start1 = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 64'(busy1), 64'd1);
    collect(-1, 0, 1'b0);
    check_std("abstart", 3, 3);

    // Start poked mid-run with new operands
    start_run(64'd10, 64'd5);
    collect(-1, 0, 1'b1);
    check_std("poke", 3, 3);
    a_in = 64'd10; b_in = 64'd5;
    @(negedge clk);
    chk("poke_no_restart", 64'(busy1), 64'd0);

    // Reset during OUT of beat 5
    start_run(64'd10, 64'd5);
    res_ready = 1'b1;
    found = 0;
    for (int t = 0; t < 60 && found == 0; t++) begin
      if (vld1 && rop1 == 4'b0100) begin
        found = 1;
        rst = 1'b1;
      end
      @(negedge clk);
    end
    chk("rst5_reach", 64'(found), 64'd1);
    chk_reset("rst5");
    rst = 1'b0;
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      if (done1 || busy1) bad++;
      @(negedge clk);
    end
    chk("rst5_quiet", 64'(bad), 64'd0);
    start_run(64'd10, 64'd5);
    collect(-1, 0, 1'b0);
    check_std("rst5_rerun", 3, 3);

    // ALU_LAT = 3 instance
    use3 = 1'b1;
    @(negedge clk);
    start_run(64'd10, 64'd5);
    collect(-1, 0, 1'b0);
    check_std("lat3", 5, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
